// File: rtl/deserializer_param_if.sv
// rtl/deserializer_param_if.sv - serial-in / word-out bus bundle for deserializer_param
//
// Purpose: groups the serial input qualifiers and the parallel word outputs.
// Signals:
//   data_i            serial data bit
//   data_val_i        data_i is valid this cycle
//   flush_i           request to emit the current partial word
//   deser_data_o      assembled word (DATA_W)
//   deser_data_mod_o  number of valid bits in deser_data_o (MOD_W)
//   deser_data_val_o  single-cycle output strobe
// Modports: master = serial source / word sink, slave = the deserializer.
interface deserializer_param_if #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W) + 1
);
    logic              data_i;
    logic              data_val_i;
    logic              flush_i;
    logic [DATA_W-1:0] deser_data_o;
    logic [MOD_W-1:0]  deser_data_mod_o;
    logic              deser_data_val_o;

    modport master (
        output data_i, data_val_i, flush_i,
        input  deser_data_o, deser_data_mod_o, deser_data_val_o
    );

    modport slave (
        input  data_i, data_val_i, flush_i,
        output deser_data_o, deser_data_mod_o, deser_data_val_o
    );
endinterface

// File: rtl/deserializer_param.sv
// rtl/deserializer_param.sv - parametrised serial-to-parallel converter with flush
//
// Purpose: packs valid-qualified serial bits into DATA_W-bit words, either
// MSB-first or LSB-first; flush emits a partial word with its bit count.
// Ports:
//   clk_i   rising-edge clock
//   arst_i  asynchronous active-high reset
//   bus     deserializer_param_if.slave (serial in, word/mod/strobe out)
module deserializer_param #(
    parameter int DATA_W    = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int MOD_W    = $clog2(DATA_W) + 1
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    deserializer_param_if.slave  bus
);
    localparam logic [MOD_W-1:0] FULL = MOD_W'(DATA_W);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [MOD_W-1:0]  cnt_q, cnt_d;
    logic [MOD_W-1:0]  mod_q, mod_d;
    logic              val_q, val_d;

    logic [MOD_W-1:0]  n;
    logic [MOD_W-1:0]  shamt;
    logic              emit;

    always_comb begin
        shreg_d = shreg_q;
        out_d   = out_q;
        mod_d   = mod_q;

        // The same-cycle bit is folded in before any emit decision.
        if (bus.data_val_i) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[DATA_W-2:0], bus.data_i};
            end else begin
                shreg_d = {bus.data_i, shreg_q[DATA_W-1:1]};
            end
        end

        n     = cnt_q + MOD_W'(bus.data_val_i);
        emit  = (n == FULL) || (bus.flush_i && (n != '0));
        shamt = FULL - n;

        // The n fresh bits sit at one end of shreg_d; shifting them to the
        // output end pushes every stale bit out and zero-fills the rest.
        // A full word has shamt = 0, so completion and flush share this path.
        if (emit) begin
            if (MSB_FIRST) begin
                out_d = shreg_d << shamt;
            end else begin
                out_d = shreg_d >> shamt;
            end
            mod_d = n;
        end

        cnt_d = emit ? '0 : n;
        val_d = emit;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
        end
    end

    assign bus.deser_data_o     = out_q;
    assign bus.deser_data_mod_o = mod_q;
    assign bus.deser_data_val_o = val_q;
endmodule

// File: tb/tb_deserializer_param.sv
// tb/tb_deserializer_param.sv - scoreboard bench for deserializer_param (MSB-first and LSB-first)
module tb_deserializer_param;
    logic clk;
    logic arst;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  mod;
        int          tgt;
    } exp_t;

    exp_t qm[$];
    exp_t ql[$];
    exp_t em;
    exp_t el;

    deserializer_param_if #(.DATA_W(16)) if_m ();
    deserializer_param_if #(.DATA_W(16)) if_l ();

    deserializer_param #(.DATA_W(16), .MSB_FIRST(1'b1)) dut_m (
        .clk_i (clk),
        .arst_i(arst),
        .bus   (if_m)
    );

    deserializer_param #(.DATA_W(16), .MSB_FIRST(1'b0)) dut_l (
        .clk_i (clk),
        .arst_i(arst),
        .bus   (if_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard monitors: one per DUT, popping on every strobe.
    always @(negedge clk) begin
        if (if_m.deser_data_val_o === 1'b1) begin
            if (qm.size() == 0) begin
                total++;
                bad++;
                $display("FAIL msb_unexpected_strobe actual=%0h required=none", if_m.deser_data_o);
            end else begin
                em = qm.pop_front();
                chk("msb_data", 32'(if_m.deser_data_o), 32'(em.data));
                chk("msb_mod", 32'(if_m.deser_data_mod_o), 32'(em.mod));
                chk("msb_cycle", 32'(cyc), 32'(em.tgt));
            end
        end
    end

    always @(negedge clk) begin
        if (if_l.deser_data_val_o === 1'b1) begin
            if (ql.size() == 0) begin
                total++;
                bad++;
                $display("FAIL lsb_unexpected_strobe actual=%0h required=none", if_l.deser_data_o);
            end else begin
                el = ql.pop_front();
                chk("lsb_data", 32'(if_l.deser_data_o), 32'(el.data));
                chk("lsb_mod", 32'(if_l.deser_data_mod_o), 32'(el.mod));
                chk("lsb_cycle", 32'(cyc), 32'(el.tgt));
            end
        end
    end

    // Called just before the input cycle whose edge produces the word.
    task automatic push_exp(input logic [15:0] md, input logic [4:0] mm,
                            input logic [15:0] ld, input logic [4:0] lm);
        exp_t e;
        e.tgt  = cyc + 1;
        e.data = md;
        e.mod  = mm;
        qm.push_back(e);
        e.data = ld;
        e.mod  = lm;
        ql.push_back(e);
    endtask

    // Drive one cycle of inputs (called at negedge), return at next negedge.
    task automatic put(input logic d, input logic v, input logic f);
        if_m.data_i     = d;
        if_l.data_i     = d;
        if_m.data_val_i = v;
        if_l.data_val_i = v;
        if_m.flush_i    = f;
        if_l.flush_i    = f;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends w MSB first; lw is the LSB-first DUT's expected word.
    task automatic send_word(input logic [15:0] w, input logic [15:0] lw,
                             input bit gaps, input bit flush_last);
        for (int i = 15; i >= 0; i--) begin
            if (i == 0) push_exp(w, 5'd16, lw, 5'd16);
            put(w[i], 1'b1, flush_last && (i == 0));
            if (gaps && i != 0) begin
                for (int g = 0; g < (i % 4) + 1; g++) begin
                    put(((g + i) % 2) == 1, 1'b0, 1'b0);
                end
            end
        end
        put(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        arst  = 1'b1;
        if_m.data_i = 1'b0; if_m.data_val_i = 1'b0; if_m.flush_i = 1'b0;
        if_l.data_i = 1'b0; if_l.data_val_i = 1'b0; if_l.flush_i = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_msb_data", 32'(if_m.deser_data_o), 32'h0);
        chk("rst_msb_mod", 32'(if_m.deser_data_mod_o), 32'h0);
        chk("rst_msb_val", 32'(if_m.deser_data_val_o), 32'h0);
        chk("rst_lsb_data", 32'(if_l.deser_data_o), 32'h0);
        arst = 1'b0;

        // Continuous words: ones then zeros, strobe spacing checked via tgt.
        for (int i = 15; i >= 0; i--) begin
            if (i == 0) push_exp(16'hFFFF, 5'd16, 16'hFFFF, 5'd16);
            put(1'b1, 1'b1, 1'b0);
        end
        for (int i = 15; i >= 0; i--) begin
            if (i == 0) push_exp(16'h0000, 5'd16, 16'h0000, 5'd16);
            put(1'b0, 1'b1, 1'b0);
        end
        put(1'b0, 1'b0, 1'b0);

        // Gapped A5C3 with data toggling during gaps.
        send_word(16'hA5C3, 16'hC3A5, 1'b1, 1'b0);

        // Partial flush with same-cycle bit: 1,0,1,1 then 0+flush.
        put(1'b1, 1'b1, 1'b0);
        put(1'b0, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        push_exp(16'hB000, 5'd5, 16'h000D, 5'd5);
        put(1'b0, 1'b1, 1'b1);
        send_word(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        // Flush with nothing collected: no strobe.
        put(1'b1, 1'b0, 1'b1);
        put(1'b0, 1'b0, 1'b0);

        // Flush coinciding with the 16th bit: one strobe, mod 16.
        send_word(16'hC001, 16'h8003, 1'b0, 1'b1);

        // Flush with no same-cycle bit after 3 bits: 1,1,0.
        put(1'b1, 1'b1, 1'b0);
        put(1'b1, 1'b1, 1'b0);
        put(1'b0, 1'b1, 1'b0);
        push_exp(16'hC000, 5'd3, 16'h0003, 5'd3);
        put(1'b0, 1'b0, 1'b1);
        put(1'b0, 1'b0, 1'b0);

        // Async reset after 7 bits, pulsed between edges.
        for (int i = 0; i < 7; i++) put(1'b1, 1'b1, 1'b0);
        if_m.data_val_i = 1'b0;
        if_l.data_val_i = 1'b0;
        #1 arst = 1'b1;
        #1;
        chk("arst_msb_data", 32'(if_m.deser_data_o), 32'h0);
        chk("arst_msb_mod", 32'(if_m.deser_data_mod_o), 32'h0);
        chk("arst_lsb_data", 32'(if_l.deser_data_o), 32'h0);
        chk("arst_lsb_mod", 32'(if_l.deser_data_mod_o), 32'h0);
        #1 arst = 1'b0;
        put(1'b0, 1'b0, 1'b0);
        send_word(16'h1234, 16'h2C48, 1'b0, 1'b0);

        repeat (20) put(1'b0, 1'b0, 1'b0);
        chk("msb_queue_drained", 32'(qm.size()), 32'h0);
        chk("lsb_queue_drained", 32'(ql.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
